// File: rtl/md_div_iter.sv
// Iterative radix-2 restoring divider for RV32 DIV/DIVU/REM/REMU.
// Takes unsigned magnitudes from the operand-conditioning stage, runs one
// quotient bit per cycle, then applies the sign fix-up in a single cycle.
module md_div_iter #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  input  logic                  kill_i,
  input  logic [2:0]            md_op_i,
  input  logic [DATA_WIDTH-1:0] X_i,
  input  logic [DATA_WIDTH-1:0] Y_i,
  input  logic                  X_sign_i,
  input  logic                  Y_sign_i,
  input  logic                  d_exception_i,
  input  logic [DATA_WIDTH-1:0] d_exception_result_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] result_o
);

  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [DATA_WIDTH-1:0] quot;
  logic [DATA_WIDTH-1:0] rem;
  logic [DATA_WIDTH-1:0] divisor;
  logic [CW-1:0]         count;
  logic [1:0]            op;
  logic                  x_sign;
  logic                  y_sign;
  logic                  accept;
  logic [DATA_WIDTH:0]   r;
  logic [DATA_WIDTH:0]   t;
  logic [DATA_WIDTH-1:0] fix_result;

  // Start acceptance: only divide ops, only in IDLE, and a flush always wins.
  assign accept = (state == IDLE) && start_i && md_op_i[2] && !kill_i;
  assign busy_o = (state != IDLE);

  // Trial subtraction of one restoring step; t[W] set means "did not fit".
  assign r = {rem, quot[DATA_WIDTH-1]};
  assign t = r - {1'b0, divisor};

  // Sign fix-up of the final quotient or remainder.
  always_comb begin
    // NOTE: default first so every path assigns the output; no latch inferred.
    fix_result = rem;
    unique case (op)
      2'b00:   fix_result = (x_sign ^ y_sign) ? -quot : quot;
      2'b01:   fix_result = quot;
      2'b10:   fix_result = x_sign ? -rem : rem;
      default: fix_result = rem;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (reset_i) state <= IDLE;
    else         state <= state_next;
  end

  // Next-state logic; a kill in CALC or FIX returns to IDLE without a result.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (accept && !d_exception_i) state_next = CALC;
      CALC:    if (kill_i) state_next = IDLE;
               else if (count == LAST) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: operand capture, one restoring iteration per CALC cycle, result.
  always_ff @(posedge clk_i) begin
    // NOTE: the working registers are cleared on reset too, so every visible
    // and internal value is defined immediately after a reset pulse.
    if (reset_i) begin
      quot     <= '0;
      rem      <= '0;
      divisor  <= '0;
      count    <= '0;
      op       <= '0;
      x_sign   <= 1'b0;
      y_sign   <= 1'b0;
      done_o   <= 1'b0;
      result_o <= '0;
    end else begin
      // NOTE: non-blocking throughout, so each register sees pre-edge values.
      done_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            op     <= md_op_i[1:0];
            x_sign <= X_sign_i;
            y_sign <= Y_sign_i;
            if (d_exception_i) begin
              result_o <= d_exception_result_i;
              done_o   <= 1'b1;
            end else begin
              quot    <= X_i;
              rem     <= '0;
              divisor <= Y_i;
              count   <= '0;
            end
          end
        end
        CALC: begin
          if (!kill_i) begin
            if (!t[DATA_WIDTH]) begin
              rem  <= t[DATA_WIDTH-1:0];
              quot <= {quot[DATA_WIDTH-2:0], 1'b1};
            end else begin
              rem  <= r[DATA_WIDTH-1:0];
              quot <= {quot[DATA_WIDTH-2:0], 1'b0};
            end
            count <= count + CW'(1);
          end
        end
        FIX: begin
          if (!kill_i) begin
            result_o <= fix_result;
            done_o   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_md_div_iter.sv
// Self-checking bench for md_div_iter: directed cases plus randomized ops
// compared against a plain-arithmetic RISC-V divide reference.
module tb_md_div_iter;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        start_i;
  logic        kill_i;
  logic [2:0]  md_op_i;
  logic [31:0] X_i;
  logic [31:0] Y_i;
  logic        X_sign_i;
  logic        Y_sign_i;
  logic        d_exception_i;
  logic [31:0] d_exception_result_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] result_o;

  int total = 0;
  int bad   = 0;

  md_div_iter #(.DATA_WIDTH(32)) dut (
    .clk_i                (clk_i),
    .reset_i              (reset_i),
    .start_i              (start_i),
    .kill_i               (kill_i),
    .md_op_i              (md_op_i),
    .X_i                  (X_i),
    .Y_i                  (Y_i),
    .X_sign_i             (X_sign_i),
    .Y_sign_i             (Y_sign_i),
    .d_exception_i        (d_exception_i),
    .d_exception_result_i (d_exception_result_i),
    .busy_o               (busy_o),
    .done_o               (done_o),
    .result_o             (result_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Reference: what the upstream stage would present, and the architectural
  // RISC-V result for the original operands a and b.
  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] x, output logic [31:0] y,
                       output logic xs, output logic ys,
                       output logic exc, output logic [31:0] res);
    int sa;
    int sb;
    bit sgn;
    sa  = a;
    sb  = b;
    sgn = (op == 3'b100) || (op == 3'b110);
    xs  = a[31];
    ys  = b[31];
    x   = (sgn && xs) ? -a : a;
    y   = (sgn && ys) ? -b : b;
    exc = 1'b0;
    if (b == 0) begin
      exc = 1'b1;
      res = op[1] ? a : 32'hFFFF_FFFF;
    end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      exc = 1'b1;
      res = op[1] ? 32'h0 : 32'h8000_0000;
    end else begin
      case (op)
        3'b100:  res = sa / sb;
        3'b101:  res = a / b;
        3'b110:  res = sa % sb;
        default: res = a % b;
      endcase
    end
  endtask

  // Issue one op from an IDLE (or done) cycle and check latency, busy and
  // result. With disturb set, inputs are scrambled and a stray start is
  // pushed mid-operation.
  task automatic run_op(input string tag, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b, input bit disturb);
    logic [31:0] x, y, exp_res;
    logic        xs, ys, exc;
    int          lat;
    int          busy_cnt;
    model(op, a, b, x, y, xs, ys, exc, exp_res);
    start_i              = 1'b1;
    md_op_i              = op;
    X_i                  = x;
    Y_i                  = y;
    X_sign_i             = xs;
    Y_sign_i             = ys;
    d_exception_i        = exc;
    d_exception_result_i = exc ? exp_res : $urandom;
    tick();
    start_i = 1'b0;
    if (disturb) begin
      md_op_i  = 3'b100 | 3'($urandom_range(3));
      X_i      = $urandom;
      Y_i      = $urandom;
      X_sign_i = $urandom_range(1);
      Y_sign_i = $urandom_range(1);
    end
    d_exception_i = 1'b0;
    lat      = 1;
    busy_cnt = 0;
    while (!done_o && lat < 60) begin
      if (busy_o) busy_cnt++;
      start_i = disturb && (lat == 5);
      tick();
      lat++;
    end
    start_i = 1'b0;
    check({tag, "_latency"}, 32'(lat), exc ? 32'd1 : 32'd34);
    check({tag, "_busy_cycles"}, 32'(busy_cnt), exc ? 32'd0 : 32'd33);
    check({tag, "_busy_at_done"}, {31'b0, busy_o}, 32'd0);
    check({tag, "_result"}, result_o, exp_res);
  endtask

  // Count done pulses over n cycles (used after kill/reset/ignored starts).
  task automatic count_done(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      if (done_o) cnt++;
      tick();
    end
  endtask

  initial begin
    logic [31:0] prev;
    logic [2:0]  op;
    logic [31:0] a, b;
    int          cnt;

    reset_i = 1'b1; start_i = 1'b0; kill_i = 1'b0; md_op_i = 3'b000;
    X_i = '0; Y_i = '0; X_sign_i = 1'b0; Y_sign_i = 1'b0;
    d_exception_i = 1'b0; d_exception_result_i = '0;
    tick(); tick();
    reset_i = 1'b0;
    check("reset_busy", {31'b0, busy_o}, 32'd0);
    check("reset_done", {31'b0, done_o}, 32'd0);
    check("reset_result", result_o, 32'd0);

    // Directed divide cases, issued back-to-back from each done cycle.
    run_op("divu_100_7",  3'b101, 32'd100, 32'd7, 1'b0);
    run_op("div_m20_3",   3'b100, -32'sd20, 32'd3, 1'b0);
    run_op("rem_m20_3",   3'b110, -32'sd20, 32'd3, 1'b0);
    run_op("remu_ff_10",  3'b111, 32'hFFFF_FFFF, 32'h10, 1'b0);
    run_op("div_by_zero", 3'b100, 32'd1234, 32'd0, 1'b0);
    run_op("div_ovf",     3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op("divu_max_1",  3'b101, 32'hFFFF_FFFF, 32'd1, 1'b0);
    run_op("divu_small_big", 3'b101, 32'd5, 32'hFFFF_FFFF, 1'b0);

    // Kill in cycle N+10 of a DIVU.
    prev    = result_o;
    start_i = 1'b1; md_op_i = 3'b101; X_i = 32'h1234_5678; Y_i = 32'd3;
    X_sign_i = 1'b0; Y_sign_i = 1'b0;
    tick();
    start_i = 1'b0;
    for (int k = 1; k < 10; k++) tick();
    kill_i = 1'b1;
    tick();
    kill_i = 1'b0;
    check("kill_busy_low", {31'b0, busy_o}, 32'd0);
    count_done(40, cnt);
    check("kill_no_done", 32'(cnt), 32'd0);
    check("kill_result_held", result_o, prev);
    run_op("after_kill", 3'b101, 32'd1000, 32'd10, 1'b0);

    // Kill on an exception start suppresses its done pulse.
    start_i = 1'b1; kill_i = 1'b1; md_op_i = 3'b100; d_exception_i = 1'b1;
    d_exception_result_i = 32'hDEAD_BEEF;
    tick();
    start_i = 1'b0; kill_i = 1'b0; d_exception_i = 1'b0;
    count_done(3, cnt);
    check("kill_exc_no_done", 32'(cnt), 32'd0);
    check("kill_exc_result", result_o, 32'd100);

    // Start with kill in IDLE, and non-divide opcodes: all ignored.
    start_i = 1'b1; kill_i = 1'b1; md_op_i = 3'b101; X_i = 32'd9; Y_i = 32'd2;
    tick();
    kill_i  = 1'b0;
    md_op_i = 3'b000;
    check("start_kill_busy", {31'b0, busy_o}, 32'd0);
    tick();
    md_op_i = 3'b011;
    check("op000_busy", {31'b0, busy_o}, 32'd0);
    tick();
    start_i = 1'b0;
    check("op011_busy", {31'b0, busy_o}, 32'd0);
    count_done(3, cnt);
    check("ignored_no_done", 32'(cnt), 32'd0);

    // Start during busy is ignored; the in-flight op still completes.
    run_op("busy_start", 3'b110, -32'sd1000, 32'd7, 1'b1);

    // Reset asserted in cycle N+20.
    start_i = 1'b1; md_op_i = 3'b101; X_i = 32'd77; Y_i = 32'd5;
    tick();
    start_i = 1'b0;
    for (int k = 1; k < 20; k++) tick();
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    check("midreset_busy", {31'b0, busy_o}, 32'd0);
    check("midreset_done", {31'b0, done_o}, 32'd0);
    check("midreset_result", result_o, 32'd0);
    count_done(40, cnt);
    check("midreset_no_done", 32'(cnt), 32'd0);

    // Randomized ops, back-to-back, with input disturbance on half of them.
    for (int i = 0; i < 40; i++) begin
      op = 3'b100 | 3'($urandom_range(3));
      a  = $urandom;
      case ($urandom_range(7))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        2:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        3:       b = -32'($urandom_range(1, 100));
        default: b = $urandom;
      endcase
      run_op("rand", op, a, b, bit'(i % 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/md_div_iter.md
Name: md_div_iter

Overview:
- Iterative radix-2 restoring divider. Sits directly downstream of the mul/div operand-conditioning stage.
- Consumes that stage's unsigned-magnitude operands and its divide-exception flag/result.
- Produces the final signed/unsigned quotient or remainder for DIV/DIVU/REM/REMU.
- RV32 only; multiply ops are not handled here.

Parameters:
- DATA_WIDTH, 32, operand/result width (RV32; the op-code wide-mode bit is tied low upstream)

Ports:
- clk_i  input  1  core clock; all state updates on rising edge
- reset_i  input  1  synchronous, active-high reset
- start_i  input  1  request; sampled only in IDLE
- kill_i  input  1  pipeline flush; synchronous abort
- md_op_i  input  3  RISC-V funct3: 100 DIV, 101 DIVU, 110 REM, 111 REMU
- X_i  input  DATA_WIDTH  dividend from upstream (magnitude if signed op, raw if unsigned)
- Y_i  input  DATA_WIDTH  divisor from upstream (same rule)
- X_sign_i  input  1  original dividend MSB
- Y_sign_i  input  1  original divisor MSB
- d_exception_i  input  1  upstream divide-by-zero/overflow flag
- d_exception_result_i  input  DATA_WIDTH  upstream architectural result for the exception case
- busy_o  output  1  high while in CALC or FIX
- done_o  output  1  one-cycle pulse, result_o valid
- result_o  output  DATA_WIDTH  quotient or remainder; held until the next accepted start

Behaviour:
- Reset (reset_i=1 at an edge; synchronous; dominates all inputs):
  - state=IDLE; busy_o=0, done_o=0, result_o=0.
  - Internal quotient, remainder, divisor and count registers cleared.
  - Applies mid-operation with no done_o.
- States: IDLE, CALC, FIX.
- IDLE:
  - Start is accepted when start_i=1, md_op_i[2]=1 and kill_i=0. Start with md_op_i[2]=0 is ignored.
  - On accept, md_op_i[1:0], X_sign_i and Y_sign_i are latched.
  - If d_exception_i=1: result_o <= d_exception_result_i, done_o=1 in the next cycle, state stays IDLE. Latency 1.
  - Otherwise: quotient reg <= X_i, remainder reg <= 0, divisor reg <= Y_i, count <= 0, state <= CALC.
- CALC, one iteration per cycle:
  - r = {remainder[W-1:0], quotient[W-1]} (W+1 bits); t = r - {0, divisor}.
  - If t[W]=0: remainder <= t[W-1:0], quotient <= {quotient[W-2:0], 1}.
  - Else: remainder <= r[W-1:0], quotient <= {quotient[W-2:0], 0}.
  - count increments; after iteration DATA_WIDTH-1 (count==W-1), state <= FIX.
- FIX, single cycle:
  - DIV (100): result = X_sign^Y_sign ? -quotient : quotient.
  - DIVU (101): result = quotient.
  - REM (110): result = X_sign ? -remainder : remainder.
  - REMU (111): result = remainder.
  - Negation is two's complement mod 2^W. Then result_o updated, done_o=1 next cycle, state <= IDLE.
- Latency: start sampled at end of cycle N → CALC cycles N+1..N+32 → FIX cycle N+33 → done_o high in cycle N+34 (W=32).
- done_o: high exactly one cycle; low otherwise.
- busy_o: 1 in CALC and FIX, 0 in IDLE including the done_o cycle. A new start may be accepted in the done_o cycle.
- start_i while busy_o=1: ignored; no effect on operands in flight.
- Latched operands: X_i, Y_i, md_op_i and the sign inputs are only sampled at accept and may change afterwards.
- kill_i=1 at an edge in CALC/FIX: state <= IDLE, no done_o, result_o keeps its previous value.
- kill_i=1 with start_i=1 in IDLE: kill wins, nothing accepted. A kill with an exception start also suppresses done_o.
- Divisor zero without d_exception_i: not possible by contract. Behaviour is natural restoring output (quotient all ones, remainder=X_i), no special case.

Test Plan:
1. DIVU, X_i=100, Y_i=7, signs 0 → done_o exactly in cycle N+34, result_o=14, busy_o high cycles N+1..N+33.
2. DIV, X_i=20, Y_i=3, X_sign_i=1, Y_sign_i=0 → result_o=0xFFFFFFFA. Same operands with REM → 0xFFFFFFFE. REMU X_i=0xFFFFFFFF, Y_i=0x10 → 0x0000000F.
3. Exception: DIV with d_exception_i=1, d_exception_result_i=0xFFFFFFFF → done_o in cycle N+1, result_o=0xFFFFFFFF, busy_o never high. Overflow case with result 0x80000000 → 0x80000000.
4. kill_i pulsed in cycle N+10 of a DIVU → busy_o low from N+11, no done_o, result_o unchanged. A following start 1000/10 → 100.
5. reset_i asserted in cycle N+20 → all outputs 0 next cycle, no done_o. start_i during busy or with md_op_i=000 → ignored, result of the in-flight op is correct.
6. Back-to-back: new start asserted in the done_o cycle → accepted, second result correct 34 cycles later. start_i and kill_i together in IDLE → not accepted.
